pipeline_ctrl: RTL and testbench

//  Sequences the 5-stage pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC: per-latch enable/flush,

---
 rtl/cpu_types_pkg.sv | 17 +
 rtl/pipeline_ctrl_hazard_unit.sv | 23 ++
 rtl/pipeline_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types for the pipeline controller
// Purpose: register-index type and pipeline controller state encoding.
// Contents: regbits_t (register index), pipectrl_state_t (RUN, MEMWAIT, DRAIN, HALTED).
package cpu_types_pkg;

   localparam int REG_W = 5;

   typedef logic [REG_W-1:0] regbits_t;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      MEMWAIT = 2'd1,
      DRAIN   = 2'd2,
      HALTED  = 2'd3
   } pipectrl_state_t;

endpackage

// File: rtl/pipeline_ctrl_hazard_unit.sv
// rtl/pipeline_ctrl_hazard_unit.sv - load-use hazard compare
// Purpose: flags a load in ID/EX whose destination feeds an operand of the instruction in IF/ID.
// Ports:
//   idex_memrd  in   ID/EX holds a load
//   idex_rd     in   ID/EX destination register
//   ifid_rs     in   IF/ID source rs
//   ifid_rt     in   IF/ID source rt
//   lu_stall    out  load-use hazard present
module hazard_unit import cpu_types_pkg::*; #(
   parameter int REG_ADDR_W = $bits(regbits_t)
) (
   input  logic                  idex_memrd,
   input  logic [REG_ADDR_W-1:0] idex_rd,
   input  logic [REG_ADDR_W-1:0] ifid_rs,
   input  logic [REG_ADDR_W-1:0] ifid_rt,
   output logic                  lu_stall
);

   // Register zero is hardwired, so a load targeting it never creates a dependency.
   assign lu_stall = idex_memrd & (idex_rd != '0) &
                     ((idex_rd == ifid_rs) | (idex_rd == ifid_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - 5-stage pipeline latch and PC sequencer
// Purpose: per-latch enable/flush, dcache wait, load-use stall, branch squash, halt drain,
//   and once-only gating of dmem requests leaving EX/MEM.
// Optional feature: PIPECTRL_STATS_EN adds the saturating stall_cnt output.
// Ports:
//   CLK, nRST                      clock, synchronous active-low reset
//   ihit, dhit                     fetch / data access complete this cycle
//   mem_dREN, mem_dWEN, mem_halt   EX/MEM latch request and halt flags
//   ex_branch                      taken branch/jump resolved in EX
//   idex_memrd, idex_rd            load in ID/EX and its destination
//   ifid_rs, ifid_rt               IF/ID source registers
//   pc_en                          PC update enable
//   <latch>_en, <latch>_flush      IF/ID, ID/EX, EX/MEM, MEM/WB controls
//   dREN, dWEN                     gated dcache requests
//   halt                           sticky halt
//   stall_cnt                      stalled cycles (PIPECTRL_STATS_EN only)
module pipeline_ctrl import cpu_types_pkg::*; #(
   parameter int REG_ADDR_W   = $bits(regbits_t),
   parameter int DRAIN_CYCLES = 2
`ifdef PIPECTRL_STATS_EN
   , parameter int CNT_W      = 32
`endif
) (
   input  logic                  CLK,
   input  logic                  nRST,
   input  logic                  ihit,
   input  logic                  dhit,
   input  logic                  mem_dREN,
   input  logic                  mem_dWEN,
   input  logic                  mem_halt,
   input  logic                  ex_branch,
   input  logic                  idex_memrd,
   input  logic [REG_ADDR_W-1:0] idex_rd,
   input  logic [REG_ADDR_W-1:0] ifid_rs,
   input  logic [REG_ADDR_W-1:0] ifid_rt,
   output logic                  pc_en,
   output logic                  ifid_en,
   output logic                  ifid_flush,
   output logic                  idex_en,
   output logic                  idex_flush,
   output logic                  exmem_en,
   output logic                  exmem_flush,
   output logic                  memwb_en,
   output logic                  memwb_flush,
   output logic                  dREN,
   output logic                  dWEN,
   output logic                  halt
`ifdef PIPECTRL_STATS_EN
   , output logic [CNT_W-1:0]    stall_cnt
`endif
);

   localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   pipectrl_state_t state_q, state_d;
   logic            mem_done_q, mem_done_d;
   logic [DW-1:0]   drain_cnt_q, drain_cnt_d;
   logic            halt_q, halt_d;

   logic mem_req, mem_busy, advance;
   logic lu_stall, lu_eff, br_sq, bubble;

   hazard_unit #(.REG_ADDR_W(REG_ADDR_W)) u_hazard (
      .idex_memrd (idex_memrd),
      .idex_rd    (idex_rd),
      .ifid_rs    (ifid_rs),
      .ifid_rt    (ifid_rt),
      .lu_stall   (lu_stall)
   );

   assign mem_req  = mem_dREN | mem_dWEN;
   // Once mem_done is set the access is finished; the latch just has to move on.
   assign mem_busy = mem_req & ~dhit & ~mem_done_q;
   assign advance  = ihit & ~mem_busy;
   // A taken branch squashes the dependent instruction, so the load-use stall is moot.
   assign lu_eff   = lu_stall & ~ex_branch;
   assign br_sq    = ex_branch & advance;
   assign bubble   = lu_eff & advance;

   assign dREN = nRST & mem_dREN & ~mem_done_q & (state_q != HALTED);
   assign dWEN = nRST & mem_dWEN & ~mem_done_q & (state_q != HALTED);
   assign halt = halt_q;

   always_comb begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b0;
      idex_en     = 1'b0;
      idex_flush  = 1'b0;
      exmem_en    = 1'b0;
      exmem_flush = 1'b0;
      memwb_en    = 1'b0;
      memwb_flush = 1'b0;

      case (state_q)
         RUN: begin
            pc_en      = advance & ~lu_eff & ~mem_halt;
            ifid_flush = br_sq;
            ifid_en    = advance & ~lu_eff & ~br_sq;
            idex_flush = br_sq | bubble;
            idex_en    = advance & ~br_sq & ~bubble;
            exmem_en   = advance;
            memwb_en   = advance;
         end
         DRAIN: begin
            // Only the halting instruction and what is ahead of it may retire.
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_en    = 1'b1;
         end
         default: ;
      endcase

      if (!nRST) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         idex_en     = 1'b0;
         exmem_en    = 1'b0;
         memwb_en    = 1'b0;
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         exmem_flush = 1'b1;
         memwb_flush = 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      drain_cnt_d = drain_cnt_q;
      halt_d      = halt_q;

      // Leaving the latch starts a new instruction, which outranks a same-cycle completion.
      if (exmem_en)
         mem_done_d = 1'b0;
      else if (dhit && state_q != HALTED)
         mem_done_d = 1'b1;
      else
         mem_done_d = mem_done_q;

      case (state_q)
         RUN: begin
            if (mem_busy)
               state_d = MEMWAIT;
            else if (mem_halt && advance) begin
               state_d     = DRAIN;
               drain_cnt_d = DW'(DRAIN_CYCLES - 1);
            end
         end
         MEMWAIT: begin
            if (dhit)
               state_d = RUN;
         end
         DRAIN: begin
            if (drain_cnt_q == '0) begin
               state_d = HALTED;
               halt_d  = 1'b1;
            end else
               drain_cnt_d = drain_cnt_q - DW'(1);
         end
         default: halt_d = 1'b1;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q     <= RUN;
         mem_done_q  <= 1'b0;
         drain_cnt_q <= '0;
         halt_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_done_q  <= mem_done_d;
         drain_cnt_q <= drain_cnt_d;
         halt_q      <= halt_d;
      end
   end

`ifdef PIPECTRL_STATS_EN
   logic [CNT_W-1:0] stall_cnt_q;

   always_ff @(posedge CLK) begin
      if (!nRST)
         stall_cnt_q <= '0;
      else if ((state_q == RUN || state_q == MEMWAIT) && !pc_en && stall_cnt_q != '1)
         stall_cnt_q <= stall_cnt_q + CNT_W'(1);
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;

   logic       CLK = 1'b0;
   logic       nRST;
   logic       ihit, dhit, mem_dREN, mem_dWEN, mem_halt, ex_branch, idex_memrd;
   logic [4:0] idex_rd, ifid_rs, ifid_rt;
   logic       pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
   logic       exmem_en, exmem_flush, memwb_en, memwb_flush;
   logic       dREN, dWEN, halt;
`ifdef PIPECTRL_STATS_EN
   logic [3:0] stall_cnt;
`endif

   int vectors = 0;
   int miscompares = 0;

   // {pc, ifid en/fl, idex en/fl, exmem en/fl, memwb en/fl, dREN, dWEN, halt}
   logic [11:0] ctl;
   assign ctl = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush,
                 memwb_en, memwb_flush, dREN, dWEN, halt};

   localparam logic [11:0] RSTV  = 12'b0_01_01_01_01_00_0;
   localparam logic [11:0] ADV   = 12'b1_10_10_10_10_00_0;
   localparam logic [11:0] IDLE  = 12'b0_00_00_00_00_00_0;
   localparam logic [11:0] WAITR = 12'b0_00_00_00_00_10_0;
   localparam logic [11:0] WR1   = 12'b0_00_00_00_00_01_0;
   localparam logic [11:0] LU    = 12'b0_00_01_10_10_00_0;
   localparam logic [11:0] BR    = 12'b1_01_01_10_10_00_0;
   localparam logic [11:0] HLT0  = 12'b0_10_10_10_10_00_0;
   localparam logic [11:0] DRN   = 12'b0_01_01_01_10_00_0;
   localparam logic [11:0] HLTD  = 12'b0_00_00_00_00_00_1;

   pipeline_ctrl #(
      .REG_ADDR_W   (5),
      .DRAIN_CYCLES (2)
`ifdef PIPECTRL_STATS_EN
      , .CNT_W      (4)
`endif
   ) dut (
      .CLK         (CLK),
      .nRST        (nRST),
      .ihit        (ihit),
      .dhit        (dhit),
      .mem_dREN    (mem_dREN),
      .mem_dWEN    (mem_dWEN),
      .mem_halt    (mem_halt),
      .ex_branch   (ex_branch),
      .idex_memrd  (idex_memrd),
      .idex_rd     (idex_rd),
      .ifid_rs     (ifid_rs),
      .ifid_rt     (ifid_rt),
      .pc_en       (pc_en),
      .ifid_en     (ifid_en),
      .ifid_flush  (ifid_flush),
      .idex_en     (idex_en),
      .idex_flush  (idex_flush),
      .exmem_en    (exmem_en),
      .exmem_flush (exmem_flush),
      .memwb_en    (memwb_en),
      .memwb_flush (memwb_flush),
      .dREN        (dREN),
      .dWEN        (dWEN),
      .halt        (halt)
`ifdef PIPECTRL_STATS_EN
      , .stall_cnt (stall_cnt)
`endif
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      @(posedge CLK);
      #1;
   endtask

   // Inputs are already driven (1 ns after an edge); check mid-cycle, then move to the next edge.
   task automatic apply(input string tag, input logic [11:0] exp);
      #3;
      chk(tag, {20'd0, ctl}, {20'd0, exp});
      cycle();
   endtask

   task automatic drive(input logic ih, input logic dh, input logic rd, input logic wr,
                        input logic hl, input logic br);
      ihit      = ih;
      dhit      = dh;
      mem_dREN  = rd;
      mem_dWEN  = wr;
      mem_halt  = hl;
      ex_branch = br;
   endtask

   initial begin
      nRST = 1'b0;
      idex_memrd = 1'b0; idex_rd = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
      drive(1, 0, 1, 0, 0, 0);
      cycle();
      apply("reset_outputs", RSTV);

      nRST = 1'b1;
      drive(1, 0, 0, 0, 0, 0);  apply("run_advance", ADV);
      drive(0, 0, 0, 0, 0, 0);  apply("run_no_ihit", IDLE);

      // Load misses for three cycles, then hits.
      drive(1, 0, 1, 0, 0, 0);  apply("lw_busy_run", WAITR);
      drive(1, 0, 1, 0, 0, 0);  apply("memwait_1", WAITR);
      drive(1, 0, 1, 0, 0, 0);  apply("memwait_2", WAITR);
      drive(1, 1, 1, 0, 0, 0);  apply("memwait_dhit", WAITR);
      drive(1, 0, 1, 0, 0, 0);
      #3; chk("exmem_en_after_dhit", {31'd0, exmem_en}, 32'd1);
      #0; apply("after_dhit_no_reissue", ADV);

      // Store hits while fetch stalls: request must not repeat until the latch moves.
      drive(0, 1, 0, 1, 0, 0);  apply("sw_hit_no_ihit", WR1);
      drive(0, 0, 0, 1, 0, 0);  apply("sw_done_held", IDLE);
      drive(1, 0, 0, 1, 0, 0);  apply("sw_done_advance", ADV);

      // Load-use hazards.
      idex_memrd = 1'b1; idex_rd = 5'd8; ifid_rs = 5'd8; ifid_rt = 5'd3;
      drive(1, 0, 0, 0, 0, 0);  apply("loaduse_rs", LU);
      ifid_rs = 5'd2; ifid_rt = 5'd8;
      apply("loaduse_rt", LU);
      idex_rd = 5'd0; ifid_rs = 5'd0;
      apply("loaduse_r0_no_stall", ADV);
      idex_rd = 5'd8; ifid_rs = 5'd8;
      drive(0, 0, 0, 0, 0, 0);  apply("loaduse_no_ihit", IDLE);
      drive(1, 0, 0, 0, 0, 1);  apply("branch_beats_loaduse", BR);

      // Branch during a dcache wait is deferred until the latch advances.
      idex_memrd = 1'b0;
      drive(1, 0, 1, 0, 0, 1);  apply("branch_busy", WAITR);
      drive(1, 1, 1, 0, 0, 1);  apply("branch_memwait_dhit", WAITR);
      drive(1, 0, 1, 0, 0, 1);  apply("branch_after_wait", BR);

      // Halt drain.
      drive(1, 0, 0, 0, 1, 0);  apply("halt_in_mem", HLT0);
      drive(0, 0, 0, 0, 0, 0);  apply("drain_1", DRN);
      drive(1, 0, 0, 0, 0, 0);  apply("drain_2", DRN);
      drive(1, 1, 1, 0, 0, 0);  apply("halted_1", HLTD);
      drive(1, 1, 0, 1, 0, 0);  apply("halted_sticky", HLTD);

      nRST = 1'b0;
      cycle();
      apply("reset_from_halted", RSTV);

      // Reset during MEMWAIT drops the access and returns to RUN.
      nRST = 1'b1;
      drive(1, 0, 1, 0, 0, 0);  apply("busy_before_reset", WAITR);
      nRST = 1'b0;
      apply("reset_in_memwait", RSTV);
      nRST = 1'b1;
      drive(1, 0, 0, 0, 0, 0);  apply("run_after_reset", ADV);

`ifdef PIPECTRL_STATS_EN
      nRST = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      cycle();
      chk("stats_reset", {28'd0, stall_cnt}, 32'd0);
      nRST = 1'b1;
      idex_memrd = 1'b1; idex_rd = 5'd8; ifid_rs = 5'd8;
      drive(1, 0, 0, 0, 0, 0);
      repeat (5) cycle();
      idex_memrd = 1'b0;
      drive(1, 0, 1, 0, 0, 0);
      cycle();
      cycle();
      drive(1, 1, 1, 0, 0, 0);
      cycle();
      drive(1, 0, 0, 0, 0, 0);
      chk("stats_eight", {28'd0, stall_cnt}, 32'd8);
      drive(0, 0, 0, 0, 0, 0);
      repeat (10) cycle();
      chk("stats_saturate", {28'd0, stall_cnt}, 32'd15);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
